// File: rtl/amc_video_timing_gen.sv
// Pixel-domain raster timing: H/V counters, blanking, sync, display enable,
// flip-aware screen coordinates, frame counter, VBL strobe and raster-line interrupt.
module amc_video_timing_gen #(
  parameter int unsigned HW           = 9,
  parameter int unsigned VW           = 9,
  parameter int unsigned H_TOTAL      = 384,
  parameter int unsigned H_ACTIVE     = 256,
  parameter int unsigned H_SYNC_START = 288,
  parameter int unsigned H_SYNC_LEN   = 32,
  parameter int unsigned V_TOTAL      = 264,
  parameter int unsigned V_START      = 16,
  parameter int unsigned V_ACTIVE     = 224,
  parameter int unsigned V_SYNC_START = 248,
  parameter int unsigned V_SYNC_LEN   = 8
) (
  input  logic          i_clk,
  input  logic          VIDEO_RSTn,
  input  logic          CE_PIXEL,
  input  logic          INVn,
  input  logic          raster_en,
  input  logic [VW-1:0] raster_line,
  output logic [HW-1:0] H,
  output logic [VW-1:0] V,
  output logic [HW-1:0] SCR_X,
  output logic [VW-1:0] SCR_Y,
  output logic          HBLANK,
  output logic          VBLANK,
  output logic          HSYNC,
  output logic          VSYNC,
  output logic          DISP,
  output logic          HLDn,
  output logic          vbl_pulse,
  output logic          raster_irq,
  output logic [7:0]    FRAME
);

  if (H_SYNC_START + H_SYNC_LEN > H_TOTAL || V_SYNC_START + V_SYNC_LEN > V_TOTAL ||
      V_START + V_ACTIVE > V_TOTAL || H_ACTIVE > H_TOTAL ||
      H_TOTAL > (1 << HW) || V_TOTAL > (1 << VW)) begin : g_bad_geometry
    $error("amc_video_timing_gen: illegal raster geometry");
  end

  // Line on which VBLANK rises (wraps to 0 when the active area ends at the frame end).
  localparam int unsigned VblLine = (V_START + V_ACTIVE) % V_TOTAL;

  logic          wrap;
  logic [HW-1:0] h_d;
  logic [VW-1:0] v_d;
  logic [7:0]    frame_d;
  logic [31:0]   h_x, v_x;
  logic          hblank_d, vblank_d, hsync_d, vsync_d, hld_n_d, vbl_d, irq_d;
  logic [HW-1:0] scr_x_d;
  logic [VW-1:0] scr_y_d;

  // Decodes are taken from the next count so they register in step with H/V.
  always_comb begin
    wrap    = (32'(H) == H_TOTAL - 1);
    h_d     = wrap ? '0 : H + HW'(1);
    v_d     = V;
    frame_d = FRAME;
    if (wrap) begin
      if (32'(V) == V_TOTAL - 1) begin
        v_d     = '0;
        frame_d = FRAME + 8'd1;
      end else begin
        v_d = V + VW'(1);
      end
    end
    h_x      = 32'(h_d);
    v_x      = 32'(v_d);
    hblank_d = (h_x >= H_ACTIVE);
    vblank_d = (v_x < V_START) || (v_x >= V_START + V_ACTIVE);
    hsync_d  = (h_x >= H_SYNC_START) && (h_x < H_SYNC_START + H_SYNC_LEN);
    vsync_d  = (v_x >= V_SYNC_START) && (v_x < V_SYNC_START + V_SYNC_LEN);
    hld_n_d  = (h_x != H_TOTAL - 1);
    scr_x_d  = (!INVn && !hblank_d) ? HW'(H_ACTIVE - 1 - h_x) : h_d;
    if (vblank_d) begin
      scr_y_d = '0;
    end else if (INVn) begin
      scr_y_d = VW'(v_x - V_START);
    end else begin
      scr_y_d = VW'(V_START + V_ACTIVE - 1 - v_x);
    end
    vbl_d = wrap && (v_x == VblLine);
    irq_d = wrap && raster_en && (v_d == raster_line);
  end

  always_ff @(posedge i_clk) begin
    if (!VIDEO_RSTn) begin
      H          <= '0;
      V          <= '0;
      FRAME      <= '0;
      SCR_X      <= '0;
      SCR_Y      <= '0;
      HBLANK     <= 1'b0;
      VBLANK     <= 1'b1;
      HSYNC      <= 1'b0;
      VSYNC      <= 1'b0;
      DISP       <= 1'b0;
      HLDn       <= 1'b1;
      vbl_pulse  <= 1'b0;
      raster_irq <= 1'b0;
    end else begin
      vbl_pulse  <= 1'b0;
      raster_irq <= 1'b0;
      if (CE_PIXEL) begin
        H          <= h_d;
        V          <= v_d;
        FRAME      <= frame_d;
        SCR_X      <= scr_x_d;
        SCR_Y      <= scr_y_d;
        HBLANK     <= hblank_d;
        VBLANK     <= vblank_d;
        HSYNC      <= hsync_d;
        VSYNC      <= vsync_d;
        DISP       <= !hblank_d && !vblank_d;
        HLDn       <= hld_n_d;
        vbl_pulse  <= vbl_d;
        raster_irq <= irq_d;
      end
    end
  end

endmodule

// File: tb/tb_amc_video_timing_gen.sv
// Bench for amc_video_timing_gen on a reduced raster; expected outputs come from the
// pixel index since reset, decomposed into line/pixel/frame by plain division.
module tb_amc_video_timing_gen;

  localparam int HW = 6, VW = 9;
  localparam int HT = 48, HA = 32, HSS = 36, HSL = 4;
  localparam int VT = 20, VS = 2, VA = 14, VSS = 17, VSL = 2;
  localparam int FR = HT * VT;

  logic          clk = 1'b0;
  logic          rst_n, ce, inv, ren;
  logic [VW-1:0] rline;
  logic [HW-1:0] h_o, sx_o;
  logic [VW-1:0] v_o, sy_o;
  logic          hb_o, vb_o, hs_o, vs_o, disp_o, hld_o, vbl_o, irq_o;
  logic [7:0]    frame_o;

  amc_video_timing_gen #(
    .HW(HW), .VW(VW), .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
    .V_TOTAL(VT), .V_START(VS), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL)
  ) dut (
    .i_clk(clk), .VIDEO_RSTn(rst_n), .CE_PIXEL(ce), .INVn(inv), .raster_en(ren),
    .raster_line(rline), .H(h_o), .V(v_o), .SCR_X(sx_o), .SCR_Y(sy_o), .HBLANK(hb_o),
    .VBLANK(vb_o), .HSYNC(hs_o), .VSYNC(vs_o), .DISP(disp_o), .HLDn(hld_o),
    .vbl_pulse(vbl_o), .raster_irq(irq_o), .FRAME(frame_o)
  );

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;
  int n;
  int e_h, e_v, e_fr, e_sx, e_sy, e_hb, e_vb, e_hs, e_vs, e_disp, e_hld, e_vbl, e_irq;
  int vbl_seen, irq_seen, vbl_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected outputs after the n-th pixel, straight from the raster rules.
  task automatic model_eval(input bit inv_s, input bit ren_s, input int rl);
    e_h    = n % HT;
    e_v    = (n / HT) % VT;
    e_fr   = (n / FR) % 256;
    e_hb   = (e_h >= HA);
    e_vb   = !(e_v >= VS && e_v < VS + VA);
    e_hs   = (e_h >= HSS && e_h < HSS + HSL);
    e_vs   = (e_v >= VSS && e_v < VSS + VSL);
    e_disp = !e_hb && !e_vb;
    e_hld  = (e_h != HT - 1);
    e_sx   = (!inv_s && e_h < HA) ? HA - 1 - e_h : e_h;
    e_sy   = e_vb ? 0 : (inv_s ? e_v - VS : VS + VA - 1 - e_v);
    e_vbl  = (e_h == 0 && e_v == VS + VA);
    e_irq  = (e_h == 0 && ren_s && rl == e_v);
  endtask

  task automatic tick();
    bit inv_s = inv, ren_s = ren, ce_s = ce, rst_s = rst_n;
    int rl = int'(rline);
    @(posedge clk);
    if (!rst_s) begin
      n = 0;
      e_h = 0; e_v = 0; e_fr = 0; e_sx = 0; e_sy = 0; e_hb = 0; e_vb = 1;
      e_hs = 0; e_vs = 0; e_disp = 0; e_hld = 1; e_vbl = 0; e_irq = 0;
    end else if (ce_s) begin
      n++;
      model_eval(inv_s, ren_s, rl);
    end else begin
      e_vbl = 0;
      e_irq = 0;
    end
    vbl_exp += e_vbl;
    #1;
    vbl_seen += int'(vbl_o);
    irq_seen += int'(irq_o);
    chk("H", 32'(h_o), e_h);
    chk("V", 32'(v_o), e_v);
    chk("FRAME", 32'(frame_o), e_fr);
    chk("SCR_X", 32'(sx_o), e_sx);
    chk("SCR_Y", 32'(sy_o), e_sy);
    chk("HBLANK", 32'(hb_o), e_hb);
    chk("VBLANK", 32'(vb_o), e_vb);
    chk("HSYNC", 32'(hs_o), e_hs);
    chk("VSYNC", 32'(vs_o), e_vs);
    chk("DISP", 32'(disp_o), e_disp);
    chk("HLDn", 32'(hld_o), e_hld);
    chk("vbl_pulse", 32'(vbl_o), e_vbl);
    chk("raster_irq", 32'(irq_o), e_irq);
  endtask

  initial begin
    int guard;
    n = 0; vbl_seen = 0; irq_seen = 0; vbl_exp = 0;
    rst_n = 1'b0; ce = 1'b1; inv = 1'b1; ren = 1'b1; rline = VW'(VS + VA);
    repeat (3) tick();
    rst_n = 1'b1;

    // Two-plus frames of random CE, occasional flip and raster-line changes.
    guard = 0;
    while (n < 2 * FR + 60 && guard < 20000) begin
      ce = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 149) == 0) inv = ~inv;
      if ($urandom_range(0, 299) == 0) rline = VW'($urandom_range(0, VT - 1));
      if ($urandom_range(0, 399) == 0) ren = ~ren;
      tick();
      guard++;
    end
    assert (guard < 20000) else begin
      mismatched++;
      $error("FAIL random_run_budget: observed %0d pixels expected %0d", n, 2 * FR + 60);
    end
    compared++;
    chk("frame_after_run", 32'(frame_o), 32'd2);
    chk("vbl_pulse_count", vbl_seen, vbl_exp);

    // Coincident strobes on the VBL line, then an out-of-range compare line never fires.
    ce = 1'b1; inv = 1'b1; ren = 1'b1; rline = VW'(VS + VA);
    irq_seen = 0; vbl_seen = 0;
    repeat (FR) tick();
    chk("irq_on_vbl_line_count", irq_seen, 32'd1);
    chk("vbl_one_frame_count", vbl_seen, 32'd1);
    rline = VW'(300);
    irq_seen = 0;
    repeat (FR) tick();
    chk("irq_line_300_count", irq_seen, 32'd0);

    // Hold CE low on the last pixel of a line.
    guard = 0;
    while (n % HT != HT - 1 && guard < 200) begin
      tick();
      guard++;
    end
    ce = 1'b0;
    repeat (50) tick();
    chk("hold_H", 32'(h_o), HT - 1);
    chk("hold_HLDn", 32'(hld_o), 32'd0);
    ce = 1'b1;
    tick();
    chk("after_hold_H", 32'(h_o), 32'd0);
    chk("after_hold_HLDn", 32'(hld_o), 32'd1);

    // Mid-frame reset, then resume from zero.
    guard = 0;
    while (!((n / HT) % VT == 10 && n % HT == 20) && guard < 2000) begin
      tick();
      guard++;
    end
    chk("pre_reset_V", 32'(v_o), 32'd10);
    rst_n = 1'b0;
    tick();
    chk("reset_H", 32'(h_o), 32'd0);
    chk("reset_V", 32'(v_o), 32'd0);
    chk("reset_VBLANK", 32'(vb_o), 32'd1);
    chk("reset_FRAME", 32'(frame_o), 32'd0);
    rst_n = 1'b1; ce = 1'b0;
    tick();
    ce = 1'b1;
    tick();
    chk("resume_H", 32'(h_o), 32'd1);
    repeat (HT) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
